// File: rtl/puf_eval_ctrl_pkg.sv
// Shared types and constants for the PUF evaluation sequencer.
package puf_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        FIRE   = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int DEF_N_BITS     = 64;
    localparam int DEF_SETTLE_CYC = 20;
    localparam int DEF_RACE_CYC   = 30;
    localparam int DEF_VOTES      = 5;

    // Width of one per-bit ones counter; it must hold 0..votes.
    function automatic int vote_cnt_w(input int votes);
        return (votes < 1) ? 1 : $clog2(votes + 1);
    endfunction

endpackage

// File: rtl/puf_eval_ctrl_if.sv
// Request and response valid/ready channels between the request source and the sequencer.
interface puf_eval_ctrl_if
    import puf_ctrl_pkg::*;
#(
    parameter int N_BITS = DEF_N_BITS
);
    logic              ReqValid;
    logic              ReqReady;
    logic [N_BITS-1:0] ReqChallenge;
    logic              RespValid;
    logic              RespReady;
    logic [N_BITS-1:0] RespData;
    logic [N_BITS-1:0] RespUnstable;

    // Request source / result consumer side.
    modport master (
        output ReqValid, ReqChallenge, RespReady,
        input  ReqReady, RespValid, RespData, RespUnstable
    );

    // Sequencer side.
    modport slave (
        input  ReqValid, ReqChallenge, RespReady,
        output ReqReady, RespValid, RespData, RespUnstable
    );
endinterface

// File: rtl/puf_vote_acc.sv
// Per-bit ones counters for majority voting over repeated PUF evaluations.
module puf_vote_acc
    import puf_ctrl_pkg::*;
#(
    parameter int N_BITS = DEF_N_BITS,
    parameter int VOTES  = DEF_VOTES
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic              clr,
    input  logic              acc_en,
    input  logic [N_BITS-1:0] bits,
    output logic [N_BITS-1:0] majority,
    output logic [N_BITS-1:0] unstable
);
    localparam int CW = vote_cnt_w(VOTES);

    logic [CW-1:0] cnt_q [N_BITS];

    // Clear on a new request, otherwise add each sampled bit to its counter.
    // NOTE: the counters are ordinary flops, so they take the async reset; an aborted request must never leak partial votes into a later result.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            for (int i = 0; i < N_BITS; i++) cnt_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < N_BITS; i++) cnt_q[i] <= '0;
        end else if (acc_en) begin
            for (int i = 0; i < N_BITS; i++) cnt_q[i] <= cnt_q[i] + CW'(bits[i]);
        end
    end

    // Majority and disagreement flags straight from the counters.
    always_comb begin
        for (int i = 0; i < N_BITS; i++) begin
            majority[i] = (cnt_q[i] > CW'(VOTES / 2));
            unstable[i] = (cnt_q[i] != '0) && (cnt_q[i] != CW'(VOTES));
        end
    end
endmodule

// File: rtl/puf_eval_ctrl.sv
// Sequencer owning the shared challenge and excite lines of the DAPUF array.
// Each request runs VOTES arm/fire/sample evaluations; the result is a
// per-bit majority vote plus a mask of bits whose votes disagreed.
// VOTES must be odd and within 1..15.
module puf_eval_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int N_BITS     = DEF_N_BITS,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int RACE_CYC   = DEF_RACE_CYC,
    parameter int VOTES      = DEF_VOTES
) (
    input  logic              Clk,
    input  logic              RstN,
    puf_eval_ctrl_if.slave    bus,
    output logic [N_BITS-1:0] PufChallenge,
    output logic              ExciteL,
    output logic              ExciteR,
    input  logic [N_BITS-1:0] PufResp,
    output logic              Busy
);
    localparam int CW     = vote_cnt_w(VOTES);
    localparam int PH_MAX = (SETTLE_CYC > RACE_CYC) ? SETTLE_CYC : RACE_CYC;
    localparam int PW     = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);

    state_e            state_q, state_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [CW-1:0]     vidx_q, vidx_d;
    logic              init_q;
    logic              excite_q;
    logic [N_BITS-1:0] chal_q;
    logic [N_BITS-1:0] data_hold_q, unst_hold_q;
    logic [N_BITS-1:0] acc_maj, acc_unst;
    logic              accept, acc_clr, acc_en;

    // init_q keeps ReqReady low until the first edge after reset release.
    assign bus.ReqReady = init_q && (state_q == IDLE);
    assign accept       = bus.ReqValid && bus.ReqReady;

    // Next-state, phase counter and vote index.
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        vidx_d  = vidx_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ARM;
                    phase_d = '0;
                    vidx_d  = '0;
                    acc_clr = 1'b1;
                end
            end
            ARM: begin
                if (phase_q == PW'(SETTLE_CYC - 1)) begin
                    state_d = FIRE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            FIRE: begin
                if (phase_q == PW'(RACE_CYC - 1)) begin
                    state_d = SAMPLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            SAMPLE: begin
                acc_en = 1'b1;
                vidx_d = vidx_q + 1'b1;
                state_d = (vidx_q == CW'(VOTES - 1)) ? DONE : ARM;
            end
            DONE: begin
                if (bus.RespReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, excite and challenge registers.
    // NOTE: non-blocking assignments here so every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            vidx_q   <= '0;
            init_q   <= 1'b0;
            excite_q <= 1'b1;
            chal_q   <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            vidx_q   <= vidx_d;
            init_q   <= 1'b1;
            excite_q <= (state_d != ARM);
            if (accept) chal_q <= bus.ReqChallenge;
        end
    end

    // Keep the delivered result visible after the handshake, while the counters are reused.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            data_hold_q <= '0;
            unst_hold_q <= '0;
        end else if (state_q == DONE) begin
            data_hold_q <= acc_maj;
            unst_hold_q <= acc_unst;
        end
    end

    puf_vote_acc #(
        .N_BITS(N_BITS),
        .VOTES (VOTES)
    ) u_vote_acc (
        .Clk     (Clk),
        .RstN    (RstN),
        .clr     (acc_clr),
        .acc_en  (acc_en),
        .bits    (PufResp),
        .majority(acc_maj),
        .unstable(acc_unst)
    );

    assign PufChallenge     = chal_q;
    assign ExciteL          = excite_q;
    assign ExciteR          = excite_q;
    assign Busy             = (state_q != IDLE);
    assign bus.RespValid    = (state_q == DONE);
    assign bus.RespData     = (state_q == DONE) ? acc_maj  : data_hold_q;
    assign bus.RespUnstable = (state_q == DONE) ? acc_unst : unst_hold_q;
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Scoreboard bench for puf_eval_ctrl: default instance plus a VOTES=1 instance.
module tb_puf_eval_ctrl;
    import puf_ctrl_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic [63:0] unst;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    puf_eval_ctrl_if #(.N_BITS(64)) bus1 ();
    puf_eval_ctrl_if #(.N_BITS(64)) bus2 ();

    logic [63:0] pch1, presp1, pch2, presp2;
    logic        exl1, exr1, busy1, exl2, exr2, busy2;

    puf_eval_ctrl u_dut1 (
        .Clk(clk), .RstN(rst_n), .bus(bus1),
        .PufChallenge(pch1), .ExciteL(exl1), .ExciteR(exr1),
        .PufResp(presp1), .Busy(busy1)
    );

    puf_eval_ctrl #(.N_BITS(64), .SETTLE_CYC(2), .RACE_CYC(3), .VOTES(1)) u_dut2 (
        .Clk(clk), .RstN(rst_n), .bus(bus2),
        .PufChallenge(pch2), .ExciteL(exl2), .ExciteR(exr2),
        .PufResp(presp2), .Busy(busy2)
    );

    // PUF array models: vote number = falling excite edges since the request.
    int falls1 = 0, falls2 = 0, base1 = 0;
    always @(negedge exl1) falls1++;
    always @(negedge exl2) falls2++;

    int          mode1 = 0;
    logic [63:0] stable_val1 = '0;
    logic [63:0] stable_val2 = '0;

    function automatic logic [63:0] model1(input int m, input logic [63:0] sv, input int v);
        logic [63:0] r;
        if (m == 0) return sv;
        r    = 64'h12345678_9ABCDEF0;
        r[0] = (v >= 1) && (v <= 3);
        r[1] = (v == 5);
        return r;
    endfunction

    assign presp1 = model1(mode1, stable_val1, falls1 - base1);
    assign presp2 = stable_val2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    exp_t q1[$];
    exp_t q2[$];

    // Scoreboard monitors: compare whenever a response handshake is about to occur.
    exp_t e1, e2;
    always @(negedge clk) begin
        if (rst_n && bus1.RespValid && bus1.RespReady) begin
            if (q1.size() == 0) check("d1_unexpected_resp", 64'd1, 64'd0);
            else begin
                e1 = q1.pop_front();
                check("d1_data", bus1.RespData, e1.data);
                check("d1_unstable", bus1.RespUnstable, e1.unst);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus2.RespValid && bus2.RespReady) begin
            if (q2.size() == 0) check("d2_unexpected_resp", 64'd1, 64'd0);
            else begin
                e2 = q2.pop_front();
                check("d2_data", bus2.RespData, e2.data);
                check("d2_unstable", bus2.RespUnstable, e2.unst);
            end
        end
    end

    // Handshake a request; k is the edge count at the accepting edge.
    task automatic send(input int sel, input logic [63:0] ch, output int k);
        int n = 0;
        forever begin
            @(negedge clk);
            if ((sel == 1) ? bus1.ReqReady : bus2.ReqReady) break;
            n++;
            if (n > 2000) begin
                check("req_ready_timeout", 64'd0, 64'd1);
                k = cyc;
                return;
            end
        end
        if (sel == 1) begin bus1.ReqValid = 1'b1; bus1.ReqChallenge = ch; end
        else          begin bus2.ReqValid = 1'b1; bus2.ReqChallenge = ch; end
        @(posedge clk);
        #1;
        k = cyc;
        if (sel == 1) bus1.ReqValid = 1'b0;
        else          bus2.ReqValid = 1'b0;
    endtask

    // Wait for RespValid; m is the edge count after which it was first seen.
    task automatic wait_valid(input int sel, output int m);
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if ((sel == 1) ? bus1.RespValid : bus2.RespValid) begin
                m = cyc;
                return;
            end
        end
        check("resp_valid_timeout", 64'd0, 64'd1);
        m = cyc;
    endtask

    int k, m;
    logic [63:0] vec2 [3];

    initial begin
        bus1.ReqValid = 1'b1; bus1.ReqChallenge = 64'hFFFF_FFFF_FFFF_FFFF; bus1.RespReady = 1'b0;
        bus2.ReqValid = 1'b1; bus2.ReqChallenge = 64'hFFFF_FFFF_FFFF_FFFF; bus2.RespReady = 1'b0;

        // Reset held for 3 cycles with a request pending.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(bus1.ReqReady), 64'd0);
        check("rst_excite_l", 64'(exl1), 64'd1);
        check("rst_excite_r", 64'(exr1), 64'd1);
        check("rst_resp_valid", 64'(bus1.RespValid), 64'd0);
        check("rst_challenge", pch1, 64'd0);
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_resp_data", bus1.RespData, 64'd0);
        check("rst_resp_unst", bus1.RespUnstable, 64'd0);
        bus1.ReqValid = 1'b0;
        bus2.ReqValid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rel_ready_before_edge", 64'(bus1.ReqReady), 64'd0);
        @(negedge clk);
        check("rel_ready_after_edge", 64'(bus1.ReqReady), 64'd1);
        check("rel_ready_after_edge2", 64'(bus2.ReqReady), 64'd1);

        // Stable PUF: constant response, unanimous votes.
        mode1 = 0;
        stable_val1 = 64'hDEADBEEF_0000FFFF;
        bus1.RespReady = 1'b1;
        base1 = falls1;
        q1.push_back('{64'hDEADBEEF_0000FFFF, 64'd0});
        send(1, 64'hAAAAAAAA_AAAAAAAA, k);
        check("stable_challenge", pch1, 64'hAAAAAAAA_AAAAAAAA);
        check("stable_excite_low", 64'({exl1, exr1}), 64'd0);
        check("stable_busy", 64'(busy1), 64'd1);
        wait_valid(1, m);
        check("stable_latency", 64'(m - k), 64'd255);
        check("stable_fall_edges", 64'(falls1 - base1), 64'd5);
        @(negedge clk);
        check("post_hs_valid", 64'(bus1.RespValid), 64'd0);
        check("post_hs_ready", 64'(bus1.ReqReady), 64'd1);
        check("post_hs_data_held", bus1.RespData, 64'hDEADBEEF_0000FFFF);

        // Noisy PUF: bit0 1,1,1,0,0 and bit1 0,0,0,0,1.
        mode1 = 1;
        base1 = falls1;
        q1.push_back('{64'h12345678_9ABCDEF1, 64'h3});
        send(1, 64'h55555555_55555555, k);
        wait_valid(1, m);
        check("noisy_latency", 64'(m - k), 64'd255);
        @(negedge clk);

        // Backpressure in DONE while a new request waits.
        @(posedge clk);
        #1 bus1.RespReady = 1'b0;
        mode1 = 0;
        stable_val1 = 64'h0F0F1234_5678F0F0;
        base1 = falls1;
        q1.push_back('{64'h0F0F1234_5678F0F0, 64'd0});
        send(1, 64'h01234567_89ABCDEF, k);
        wait_valid(1, m);
        bus1.ReqValid = 1'b1;
        bus1.ReqChallenge = 64'hFFFF0000_FFFF0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(bus1.RespValid), 64'd1);
            check("bp_no_accept", 64'(bus1.ReqReady), 64'd0);
            check("bp_challenge", pch1, 64'h01234567_89ABCDEF);
            check("bp_data", bus1.RespData, 64'h0F0F1234_5678F0F0);
            check("bp_unst", bus1.RespUnstable, 64'd0);
        end
        @(posedge clk);
        #1 bus1.RespReady = 1'b1;
        stable_val1 = 64'hCAFEF00D_00000001;
        base1 = falls1;
        q1.push_back('{64'hCAFEF00D_00000001, 64'd0});
        @(negedge clk);
        check("bp_release_ready_low", 64'(bus1.ReqReady), 64'd0);
        @(negedge clk);
        check("bp_idle_ready", 64'(bus1.ReqReady), 64'd1);
        check("bp_idle_valid", 64'(bus1.RespValid), 64'd0);
        check("bp_idle_challenge", pch1, 64'h01234567_89ABCDEF);
        check("bp_idle_busy", 64'(busy1), 64'd0);
        @(negedge clk);
        check("bp_accept_challenge", pch1, 64'hFFFF0000_FFFF0000);
        check("bp_accept_busy", 64'(busy1), 64'd1);
        bus1.ReqValid = 1'b0;
        wait_valid(1, m);
        @(negedge clk);

        // Reset during FIRE of vote 3, then a fresh full request.
        mode1 = 1;
        base1 = falls1;
        send(1, 64'h3C3C3C3C_3C3C3C3C, k);
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if ((falls1 - base1) == 3 && exl1 === 1'b1) break;
        end
        check("abort_in_vote3", 64'(falls1 - base1), 64'd3);
        rst_n = 1'b0;
        #1;
        check("abort_excite_l", 64'(exl1), 64'd1);
        check("abort_excite_r", 64'(exr1), 64'd1);
        check("abort_valid", 64'(bus1.RespValid), 64'd0);
        check("abort_busy", 64'(busy1), 64'd0);
        check("abort_ready", 64'(bus1.ReqReady), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        base1 = falls1;
        q1.push_back('{64'h12345678_9ABCDEF1, 64'h3});
        send(1, 64'h3C3C3C3C_3C3C3C3C, k);
        wait_valid(1, m);
        check("abort_refresh_latency", 64'(m - k), 64'd255);
        check("abort_refresh_falls", 64'(falls1 - base1), 64'd5);
        @(negedge clk);

        // VOTES=1, SETTLE_CYC=2, RACE_CYC=3 instance.
        bus2.RespReady = 1'b1;
        vec2[0] = 64'h0;
        vec2[1] = 64'hFFFFFFFF_FFFFFFFF;
        vec2[2] = 64'h80000001_A5A55A5A;
        for (int i = 0; i < 3; i++) begin
            stable_val2 = vec2[i];
            q2.push_back('{vec2[i], 64'd0});
            send(2, ~vec2[i], k);
            check("v1_challenge", pch2, ~vec2[i]);
            wait_valid(2, m);
            check("v1_latency", 64'(m - k), 64'd6);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("q1_drained", 64'(q1.size()), 64'd0);
        check("q2_drained", 64'(q2.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/puf_eval_ctrl.md
# puf_eval_ctrl

Sequencer that owns the 64-instance DAPUF array's shared challenge and excite lines. It accepts challenge requests over a valid/ready handshake and runs VOTES arm/fire/sample evaluations per challenge. It returns a per-bit majority-voted response with an instability mask over a second valid/ready handshake. It replaces the free-running iteration counter in the key-generation top, between the request source (switch logic / host) and the PUF array.

## Interface
Parameters:
- N_BITS, 64, response width (number of PUF instances) and challenge width
- SETTLE_CYC, 20, cycles excite held low with challenge stable before firing
- RACE_CYC, 30, cycles excite held high before sampling the response
- VOTES, 5, evaluations per request; must be odd, 1..15

Ports:
- Clk  in  1  single clock, rising edge
- RstN  in  1  asynchronous active-low reset
- ReqValid  in  1  request present
- ReqReady  out  1  controller can accept a request (IDLE only)
- ReqChallenge  in  N_BITS  challenge, captured on handshake
- PufChallenge  out  N_BITS  challenge driven to every PUF instance
- ExciteL  out  1  left-path excite to array
- ExciteR  out  1  right-path excite to array
- PufResp  in  N_BITS  raw arbiter outputs from the array
- RespValid  out  1  voted result available
- RespReady  in  1  consumer accepts result
- RespData  out  N_BITS  majority-voted response
- RespUnstable  out  N_BITS  bit i = 1 if votes for bit i were not unanimous
- Busy  out  1  state != IDLE

## Operation
- States: IDLE, ARM, FIRE, SAMPLE, DONE.
- IDLE:
  - ReqReady=1, ExciteL/R=1.
  - On ReqValid&&ReqReady: latch ReqChallenge into PufChallenge, clear vote counters and vote index, go to ARM.
- ARM: ExciteL=ExciteR=0 for SETTLE_CYC cycles, then go to FIRE.
- FIRE: ExciteL=ExciteR=1 for RACE_CYC cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - Per bit, ones[i] += PufResp[i]; vote index += 1.
  - If index reaches VOTES, go to DONE, else go to ARM.
- DONE:
  - RespValid=1; RespData[i] = (ones[i] > VOTES/2); RespUnstable[i] = (ones[i] != 0 && ones[i] != VOTES).
  - Hold all outputs stable until RespReady, then go to IDLE.
- Vote counters are $clog2(VOTES+1) bits each and saturate by construction (max VOTES).
- PufChallenge changes only at a request handshake; it holds its last value in IDLE and DONE.
- ExciteL and ExciteR are always driven identically, both from one register.
- ReqValid is ignored outside IDLE. A request cannot be accepted in the same cycle DONE completes; the earliest acceptance is the following IDLE cycle.

## Timing
- Reset (RstN low, asynchronous) forces:
  - state=IDLE, ReqReady=0, ExciteL=ExciteR=1
  - PufChallenge=0, RespValid=0, RespData=0, RespUnstable=0, Busy=0
- ReqReady rises at the first Clk edge after RstN deasserts.
- Handshake at edge k: ExciteL/R fall after edge k, and PufChallenge is valid after edge k.
- One vote takes SETTLE_CYC+RACE_CYC+1 cycles. PufResp is sampled on the edge that ends SAMPLE, i.e. RACE_CYC+1 edges after excite rises.
- RespValid rises after edge k + VOTES*(SETTLE_CYC+RACE_CYC+1). With defaults that is k+255.
- RespValid&&RespReady at edge m: RespValid=0 and ReqReady=1 after edge m.
- RespData and RespUnstable keep their values after the handshake until the next DONE.
- Reset mid-operation aborts immediately: the excite lines return high and partial votes are discarded.

## Structure
- Package puf_ctrl_pkg: state enum (IDLE, ARM, FIRE, SAMPLE, DONE), default parameter constants, and a function computing the vote counter width.
- Sub-module puf_vote_acc: an N_BITS array of counters with clear, accumulate-enable and VOTES inputs, producing the majority and unstable vectors combinationally from its counters.
- The phase counter (shared by ARM and FIRE) and the vote index live in the top FSM.

## Test plan
- Reset: hold RstN low for 3 cycles with ReqValid=1 -> ReqReady=0, ExciteL/R=1, RespValid=0; ReqReady=1 one edge after release.
- Stable PUF model: PufResp=64'hDEADBEEF0000FFFF constant, request 64'hAAAAAAAAAAAAAAAA -> RespData=64'hDEADBEEF0000FFFF, RespUnstable=0, RespValid exactly 255 cycles after handshake, exactly 5 falling excite edges.
- Noisy model: bit 0 is 1 on votes 1,2,3 and 0 on votes 4,5; bit 1 is 1 on vote 5 only -> RespData[1:0]=2'b01, RespUnstable[1:0]=2'b11.
- Backpressure: RespReady=0 for 10 cycles in DONE while ReqValid=1 with a new challenge -> outputs stable, PufChallenge unchanged, no acceptance; release -> IDLE then acceptance next edge.
- Reset asserted mid-FIRE of vote 3 -> excite lines immediately 1, RespValid stays 0; a fresh request completes with the correct full 5-vote result.
- Parameters VOTES=1, SETTLE_CYC=2, RACE_CYC=3 -> latency 6 cycles, RespUnstable always 0.
